mux4_1_registered: RTL and testbench

- Four-input, one-output selector for a WIDTH-bit datapath, with a registered output stage.
- A 2-bit select ({s1,s0}) picks one of inputs a/b/c/d.
- A combinational result is also exported for timing-insensitive consumers.
- Used as a generic leaf selector wherever a clean, glitch-free, reset-defined select result is needed.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/mux4_core.sv | 31 +++
 rtl/mux4_1_registered.sv | 65 ++++++
 tb/tb_mux4_1_registered.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared select encoding for the 4:1 selector family.
// Contents: sel_t (2-bit select), SEL_A..SEL_D constants, and make_sel()
// to build a select from its split bit inputs.
package mux_pkg;

  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;

  // s1 is the MSB, s0 the LSB.
  function automatic sel_t make_sel(input logic s1, input logic s0);
    return {s1, s0};
  endfunction

endpackage : mux_pkg

// File: rtl/mux4_core.sv
// Combinational WIDTH-bit 4:1 selector.
// Ports:
//   a, b, c, d : data inputs 0..3
//   sel        : select, SEL_A..SEL_D pick a..d
//   y          : selected input; all-X for an unknown select
module mux4_core
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  // Unknown select falls through to all-X; no priority fallback to any input.
  always_comb begin
    y = {WIDTH{1'bx}};
    case (sel)
      SEL_A: y = a;
      SEL_B: y = b;
      SEL_C: y = c;
      SEL_D: y = d;
      default: y = {WIDTH{1'bx}};
    endcase
  end

endmodule : mux4_core

// File: rtl/mux4_1_registered.sv
// Four-input selector with registered output and valid flag.
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   a, b, c, d      : WIDTH-bit data inputs 0..3
//   s0, s1          : select bits (s1 is MSB)
//   in_valid        : qualifies the current input sample
//   y_comb          : combinational selection, zero latency
//   y               : registered selection, updated only when in_valid
//   y_valid         : registered in_valid, aligned with y
module mux4_1_registered
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH     = 1,
  parameter logic [63:0] RESET_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s0,
  input  logic             s1,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y_comb,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  localparam logic [WIDTH-1:0] RST_Y = RESET_VAL[WIDTH-1:0];

  sel_t sel;

  assign sel = make_sel(s1, s0);

  mux4_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .y   (y_comb)
  );

  // Output register: capture only qualified samples, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= RST_Y;
    end else if (in_valid) begin
      y <= y_comb;
    end
  end

  // Valid flag follows in_valid every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 1'b0;
    end else begin
      y_valid <= in_valid;
    end
  end

endmodule : mux4_1_registered

// File: tb/tb_mux4_1_registered.sv
// Self-checking bench: a WIDTH=1 and a WIDTH=8 instance share control inputs
// and are compared against an array-indexed reference model.
module tb_mux4_1_registered;

  localparam logic [7:0] RST8 = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       s0, s1, in_valid;
  logic       a1, b1, c1, d1;
  logic [7:0] a8, b8, c8, d8;
  logic       yc1, y1, yv1;
  logic [7:0] yc8, y8, yv8_dummy;
  logic       yv8;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic       m_y1;
  logic [7:0] m_y8;
  logic       m_yv;

  always #5 clk = ~clk;

  mux4_1_registered #(.WIDTH(1), .RESET_VAL(64'd0)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1),
    .s0(s0), .s1(s1), .in_valid(in_valid),
    .y_comb(yc1), .y(y1), .y_valid(yv1)
  );

  mux4_1_registered #(.WIDTH(8), .RESET_VAL({56'd0, RST8})) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8),
    .s0(s0), .s1(s1), .in_valid(in_valid),
    .y_comb(yc8), .y(y8), .y_valid(yv8)
  );

  assign yv8_dummy = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: the select indexes the list of inputs; unknown select gives X.
  function automatic logic pick1(input logic [1:0] sel);
    logic ins [4];
    ins[0] = a1; ins[1] = b1; ins[2] = c1; ins[3] = d1;
    if ($isunknown(sel)) return 1'bx;
    return ins[sel];
  endfunction

  function automatic logic [7:0] pick8(input logic [1:0] sel);
    logic [7:0] ins [4];
    ins[0] = a8; ins[1] = b8; ins[2] = c8; ins[3] = d8;
    if ($isunknown(sel)) return 8'bxxxxxxxx;
    return ins[sel];
  endfunction

  // One step: inputs already driven; check comb, clock once, check registers.
  task automatic step(input string tag);
    logic [1:0] sel;
    logic       e1;
    logic [7:0] e8;
    sel = {s1, s0};
    #1;
    e1 = pick1(sel);
    e8 = pick8(sel);
    chk({tag, ".yc1"}, 64'(yc1), 64'(e1));
    chk({tag, ".yc8"}, 64'(yc8), 64'(e8));
    if (in_valid) begin
      m_y1 = e1;
      m_y8 = e8;
    end
    m_yv = in_valid;
    @(posedge clk);
    #1;
    chk({tag, ".y1"},  64'(y1),  64'(m_y1));
    chk({tag, ".y8"},  64'(y8),  64'(m_y8));
    chk({tag, ".yv1"}, 64'(yv1), 64'(m_yv));
    chk({tag, ".yv8"}, 64'(yv8), 64'(m_yv));
  endtask

  initial begin
    // Reset with no clock edge: registers cleared, comb path live.
    rst = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0;
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    s1 = 1'b0; s0 = 1'b0; in_valid = 1'b1;
    #1;
    chk("rst.y1",  64'(y1),  64'd0);
    chk("rst.y8",  64'(y8),  64'(RST8));
    chk("rst.yv1", 64'(yv1), 64'd0);
    chk("rst.yv8", 64'(yv8), 64'd0);
    chk("rst.yc1", 64'(yc1), 64'd1);
    chk("rst.yc8", 64'(yc8), 64'h11);
    #2;
    rst = 1'b0;
    m_y1 = 1'b0; m_y8 = RST8; m_yv = 1'b0;

    // Exhaustive WIDTH=1 sweep; {a,b,c,d} with a as MSB.
    for (int v = 0; v < 16; v++) begin
      for (int s = 0; s < 4; s++) begin
        logic [3:0] vv;
        logic [1:0] ss;
        vv = 4'(v); ss = 2'(s);
        {a1, b1, c1, d1} = vv;
        {s1, s0} = ss;
        {a8, b8, c8, d8} = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        in_valid = 1'b1;
        step("sweep");
      end
    end

    // Spot example: a,b,c,d=0,1,1,0, sel=01 -> b=1.
    {a1, b1, c1, d1} = 4'b0110; {s1, s0} = 2'b01; in_valid = 1'b1;
    step("ex01");
    chk("ex01.abs", 64'(y1), 64'd1);

    // Hold: capture d=1, then drop in_valid and change d.
    {a1, b1, c1, d1} = 4'b0001; {s1, s0} = 2'b11; in_valid = 1'b1;
    step("hold.cap");
    d1 = 1'b0; in_valid = 1'b0;
    step("hold.keep");
    chk("hold.abs", 64'(y1), 64'd1);

    // Async reset between edges, held across an edge.
    rst = 1'b1;
    #1;
    m_y1 = 1'b0; m_y8 = RST8; m_yv = 1'b0;
    chk("arst.y1",  64'(y1),  64'd0);
    chk("arst.y8",  64'(y8),  64'(RST8));
    chk("arst.yv1", 64'(yv1), 64'd0);
    in_valid = 1'b1; d1 = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.hold.y1",  64'(y1),  64'd0);
    chk("arst.hold.yv8", 64'(yv8), 64'd0);
    rst = 1'b0;
    {a1, b1, c1, d1} = 4'b0010; {s1, s0} = 2'b10; in_valid = 1'b1;
    step("arst.first");
    chk("arst.first.abs", 64'(y1), 64'd1);

    // WIDTH=8 directed cycle through all selects.
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    for (int s = 0; s < 4; s++) begin
      logic [1:0] ss;
      ss = 2'(s);
      {s1, s0} = ss;
      step("w8");
      chk("w8.abs", 64'(y8), 64'(8'h11 * (s + 1)));
    end

    // Unknown select: comb and captured value go X until a known select is clocked.
    s1 = 1'bx; s0 = 1'b0; in_valid = 1'b1;
    step("xsel");
    {s1, s0} = 2'b01;
    step("xsel.clear");

    // Randomised phase with random in_valid.
    for (int i = 0; i < 200; i++) begin
      logic [1:0] ss;
      ss = 2'($urandom);
      {s1, s0} = ss;
      {a1, b1, c1, d1} = 4'($urandom);
      {a8, b8, c8, d8} = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      in_valid = 1'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux4_1_registered
